// File: rtl/mac_sequencer.sv
// mac_sequencer: shift-and-add MAC controller pulling len (a,b) pairs into an accumulator
// ports: clk, reset (async active-low), start/len launch a run; in_valid/in_a/in_b/in_ready operand handshake;
//        busy (not idle), done (one-cycle end pulse), acc_out (running sum), overflow (sticky carry-out)
module mac_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow
);
  localparam int SW = $clog2(DATA_W + 1);
  typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, DONE} state_t;
  state_t              state, nxt;
  logic [CNT_W-1:0]    cnt;
  logic [SW-1:0]       step;
  logic [2*DATA_W-1:0] mcand, prod;
  logic [DATA_W-1:0]   mplr;
  logic [ACC_W:0]      sum;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? (len != '0 ? LOAD : DONE) : IDLE;
      LOAD:    nxt = in_valid ? MUL : LOAD;
      MUL:     nxt = step == SW'(DATA_W - 1) ? ACC : MUL;
      ACC:     nxt = cnt == CNT_W'(1) ? DONE : LOAD;
      default: nxt = IDLE;
    endcase
  end
  assign in_ready = state == LOAD;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  // top bit is the carry-out that feeds the sticky overflow flag
  assign sum      = {1'b0, acc_out} + (ACC_W + 1)'(prod);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc_out  <= '0;
      overflow <= 1'b0;
      cnt      <= '0;
      step     <= '0;
      mcand    <= '0;
      mplr     <= '0;
      prod     <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          acc_out  <= '0;
          overflow <= 1'b0;
          cnt      <= len;
        end
        LOAD: if (in_valid) begin
          mcand <= (2*DATA_W)'(in_a);
          mplr  <= in_b;
          prod  <= '0;
          step  <= '0;
        end
        MUL: begin
          if (mplr[0]) prod <= prod + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          step  <= step + SW'(1);
        end
        ACC: begin
          acc_out  <= sum[ACC_W-1:0];
          overflow <= overflow | sum[ACC_W];
          cnt      <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: randomized and directed runs against a pair-level arithmetic and timing model
module tb_mac_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_ready, busy, done, overflow;
  logic [15:0] acc_out;
  int          checks = 0;
  int          errors = 0;
  int          qa [16];
  int          qb [16];
  logic [15:0] acc_e;
  logic        ov_e;
  mac_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_ready(in_ready), .busy(busy), .done(done),
    .acc_out(acc_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // one run of n pairs from qa/qb; stall = LOAD cycles with in_valid low before each pair;
  // start is re-pulsed (with a random len) in cycles plo..phi to probe that it is ignored
  task automatic run(input int n, input int stall, input int plo, input int phi);
    int idx = 0;
    int wl = stall;
    int load_at = 1;
    int done_at = (n == 0) ? 1 : -1;
    int cyc = 0;
    logic rdy_e;
    logic [16:0] t;
    @(posedge clk); #1;
    start = 1'b1; len = 4'(n); in_valid = 1'b0;
    acc_e = '0; ov_e = 1'b0;
    while (1) begin
      @(negedge clk);
      rdy_e = idx < n && cyc >= load_at;
      check("in_ready", in_ready, rdy_e);
      check("busy", busy, cyc >= 1 && (done_at < 0 || cyc <= done_at));
      check("done", done, cyc == done_at);
      if (rdy_e) check("acc_hold", acc_out, acc_e);
      if (in_ready && in_valid) begin
        t = {1'b0, acc_e} + 17'(qa[idx] * qb[idx]);
        acc_e = t[15:0];
        ov_e = ov_e | t[16];
        idx++;
        wl = stall;
        load_at = cyc + 10;
        if (idx == n) done_at = cyc + 10;
      end else if (in_ready && wl > 0) wl--;
      if (done_at >= 0 && cyc == done_at + 1) break;
      if (cyc > 400) begin
        check("timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      start = cyc >= plo && cyc <= phi;
      len = 4'($urandom_range(1, 15));
      in_valid = idx < n && wl == 0;
      if (in_valid) begin
        in_a = 8'(qa[idx]);
        in_b = 8'(qb[idx]);
      end
    end
    start = 1'b0; in_valid = 1'b0;
    check("acc_out", acc_out, acc_e);
    check("overflow", overflow, ov_e);
  endtask
  initial begin
    #2;
    check("rst_acc", acc_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    #20 reset = 1'b1;
    qa[0] = 3; qb[0] = 5;
    run(1, 0, 1, 0);
    check("t1_acc", acc_out, 15);
    qa[0] = 255; qb[0] = 255; qa[1] = 255; qb[1] = 255;
    run(2, 0, 1, 0);
    check("t2_acc", acc_out, 64514);
    check("t2_ovf", overflow, 1);
    qa[0] = 1; qb[0] = 2; qa[1] = 3; qb[1] = 4; qa[2] = 5; qb[2] = 6;
    run(3, 3, 1, 0);
    check("t3_acc", acc_out, 44);
    run(0, 0, 1, 0);
    check("t4_zero", acc_out, 0);
    qa[0] = 8'h80; qb[0] = 2;
    run(1, 0, 2, 5);
    check("t4_acc", acc_out, 256);
    qa[0] = 11; qb[0] = 13;
    run(1, 0, 11, 11);
    check("t4_done_start", acc_out, 143);
    @(posedge clk); #1;
    start = 1'b1; len = 4'd2; in_valid = 1'b1; in_a = 8'd200; in_b = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("t5_pre_acc", acc_out, 40000);
    check("t5_pre_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_acc", acc_out, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", in_ready, 0);
    check("t5_done", done, 0);
    check("t5_ovf", overflow, 0);
    in_valid = 1'b0;
    #13 reset = 1'b1;
    qa[0] = 7; qb[0] = 9;
    run(1, 0, 1, 0);
    check("t5_acc2", acc_out, 63);
    check("t5_ovf2", overflow, 0);
    qa[0] = 0; qb[0] = 200; qa[1] = 200; qb[1] = 0;
    run(2, 0, 1, 0);
    check("t6_acc", acc_out, 0);
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
        qa[i] = $urandom_range(0, 255);
        qb[i] = $urandom_range(0, 255);
      end
      run(n, $urandom_range(0, 3), 1, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
